// File: rtl/pipelined_barrel_shifter.sv
// SLL/SRL/SRA/ROR over SHW registered stages (stage k shifts by 2^k). Latency SHW cycles.
// Global stall: every stage holds while out_valid && !out_ready, and in_ready drops.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [$clog2(WIDTH)-1:0]  in_amt,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [SHW-1:0]   amt_d  [SHW];
  logic [1:0]       mode_q [SHW];
  logic [1:0]       mode_d [SHW];
  logic [SHW-1:0]   vld_q, vld_d;
  logic [SHW-1:0]   sign_q, sign_d;
  logic             stall;
  logic             unused_ctrl;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] mode,
                                                  input logic sign,
                                                  input int sh);
    logic [WIDTH-1:0] res;
    res = '0;
    case (mode)
      MODE_SLL: res = d << sh;
      MODE_SRL: res = d >> sh;
      MODE_SRA: res = (d >> sh) | (sign ? ~({WIDTH{1'b1}} >> sh) : {WIDTH{1'b0}});
      default:  res = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return res;
  endfunction

  always_comb begin
    stall  = vld_q[SHW-1] & ~out_ready;
    vld_d  = vld_q;
    sign_d = sign_q;
    for (int k = 0; k < SHW; k++) begin
      data_d[k] = data_q[k];
      amt_d[k]  = amt_q[k];
      mode_d[k] = mode_q[k];
    end
    if (!stall) begin
      // in_ready is 1 whenever we get here, so in_valid alone is the accept
      vld_d[0]  = in_valid;
      amt_d[0]  = in_amt;
      mode_d[0] = in_mode;
      sign_d[0] = in_data[WIDTH-1];
      data_d[0] = in_amt[0] ? shift_step(in_data, in_mode, in_data[WIDTH-1], 1) : in_data;
      for (int k = 1; k < SHW; k++) begin
        vld_d[k]  = vld_q[k-1];
        amt_d[k]  = amt_q[k-1];
        mode_d[k] = mode_q[k-1];
        sign_d[k] = sign_q[k-1];
        data_d[k] = amt_q[k-1][k] ? shift_step(data_q[k-1], mode_q[k-1], sign_q[k-1], 1 << k)
                                  : data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      sign_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      sign_q <= sign_d;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= amt_d[k];
        mode_q[k] <= mode_d[k];
      end
    end
  end

  // Last-stage control and already-consumed amount bits have no reader.
  always_comb begin
    unused_ctrl = ^{mode_q[SHW-1], sign_q[SHW-1]};
    for (int k = 0; k < SHW; k++) begin
      unused_ctrl = unused_ctrl ^ (^amt_q[k]);
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = vld_q[SHW-1];
  assign out_data  = data_q[SHW-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench: WIDTH 8/4/16 shifters side by side; vectors, random streams, backpressure and resets.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv    [3];
  logic        irdy  [3];
  logic [31:0] idat  [3];
  logic [31:0] iamt  [3];
  logic [1:0]  imode [3];
  logic        ov    [3];
  logic        ordy  [3];
  logic [31:0] odat  [3];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pat = 0;
  int ordy_mode = 0;

  logic [31:0] sb_dat [3][512];
  int          sb_cyc [3][512];
  int          sb_stl [3][512];
  int          wp  [3] = '{0, 0, 0};
  int          rp  [3] = '{0, 0, 0};
  int          stl [3] = '{0, 0, 0};
  logic        was_stall [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] prev_dat  [3];
  logic        st [3];

  typedef struct {
    logic [7:0] d;
    int         a;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W = (g == 0) ? 8 : (g == 1) ? 4 : 16;
    localparam int S = $clog2(W);
    logic         ir, ovl;
    logic [W-1:0] od;
    pipelined_barrel_shifter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(iv[g]), .in_ready(ir),
      .in_data(idat[g][W-1:0]), .in_amt(iamt[g][S-1:0]), .in_mode(imode[g]),
      .out_valid(ovl), .out_ready(ordy[g]), .out_data(od)
    );
    assign irdy[g] = ir;
    assign ov[g]   = ovl;
    assign odat[g] = 32'(od);
  end

  function automatic int lane_w(input int l);
    return (l == 0) ? 8 : (l == 1) ? 4 : 16;
  endfunction

  function automatic int lane_s(input int l);
    return $clog2(lane_w(l));
  endfunction

  // Reference: whole-word shift/rotate by the full amount in one step.
  function automatic logic [31:0] model(input int w, input logic [31:0] d, input int a,
                                        input logic [1:0] m);
    logic [31:0] mask;
    logic [31:0] x;
    mask = (32'd1 << w) - 32'd1;
    x = d & mask;
    case (m)
      2'b00:   return (x << a) & mask;
      2'b01:   return x >> a;
      2'b10:   return x[w-1] ? ((x >> a) | (mask & ~(mask >> a))) : (x >> a);
      default: return ((x >> a) | (x << (w - a))) & mask;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Call aligned just after a rising edge; returns aligned just after the accepting edge.
  task automatic send(input int l, input logic [31:0] d, input int a, input logic [1:0] m,
                      input logic [31:0] e);
    int n;
    n = 0;
    iv[l] = 1'b1; idat[l] = d; iamt[l] = a; imode[l] = m;
    forever begin
      @(negedge clk);
      if (irdy[l] && !rst) begin
        sb_dat[l][wp[l] % 512] = e;
        sb_cyc[l][wp[l] % 512] = cyc;
        sb_stl[l][wp[l] % 512] = stl[l];
        wp[l]++;
        break;
      end
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout lane %0d: in_ready low for %0d cycles, required high", l, n);
        break;
      end
    end
    @(posedge clk); #1;
    iv[l] = 1'b0;
  endtask

  task automatic send_rand(input int l);
    logic [31:0] d;
    int a;
    logic [1:0] m;
    if ($urandom_range(0, 4) == 0) begin
      @(posedge clk); #1;
    end
    d = $urandom;
    a = $urandom_range(0, lane_w(l) - 1);
    m = 2'($urandom_range(0, 3));
    send(l, d, a, m, model(lane_w(l), d, a, m));
  endtask

  always @(posedge clk) begin
    #1;
    pat = pat + 1;
    for (int l = 0; l < 3; l++) begin
      case (ordy_mode)
        0:       ordy[l] = 1'b1;
        1:       ordy[l] = (pat % 3 == 0);
        default: ordy[l] = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard order/value, latency incl. stall cycles, in_ready, hold while stalled.
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (rst) begin
        rp[l] = wp[l];
        was_stall[l] = 1'b0;
      end else begin
        st[l] = ov[l] && !ordy[l];
        chk($sformatf("in_ready_l%0d", l), 32'(irdy[l]), 32'(!st[l]));
        chk($sformatf("spurious_out_l%0d", l), 32'(ov[l] && (rp[l] == wp[l])), 32'd0);
        if (was_stall[l]) chk($sformatf("stall_hold_l%0d", l), odat[l], prev_dat[l]);
        if (ov[l] && ordy[l] && (rp[l] != wp[l])) begin
          chk($sformatf("data_l%0d", l), odat[l], sb_dat[l][rp[l] % 512]);
          chk($sformatf("latency_l%0d", l), 32'(cyc - sb_cyc[l][rp[l] % 512]),
              32'(lane_s(l) + stl[l] - sb_stl[l][rp[l] % 512]));
          rp[l]++;
        end
        if (st[l]) stl[l]++;
        was_stall[l] = st[l];
        prev_dat[l]  = odat[l];
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h81, 3, 2'b00, 8'h08};
    tbl[1]  = '{8'h81, 3, 2'b01, 8'h10};
    tbl[2]  = '{8'h81, 3, 2'b10, 8'hF0};
    tbl[3]  = '{8'h81, 3, 2'b11, 8'h30};
    tbl[4]  = '{8'hA5, 0, 2'b00, 8'hA5};
    tbl[5]  = '{8'hA5, 0, 2'b01, 8'hA5};
    tbl[6]  = '{8'hA5, 0, 2'b10, 8'hA5};
    tbl[7]  = '{8'hA5, 0, 2'b11, 8'hA5};
    tbl[8]  = '{8'h81, 7, 2'b00, 8'h80};
    tbl[9]  = '{8'h81, 7, 2'b01, 8'h01};
    tbl[10] = '{8'h81, 7, 2'b10, 8'hFF};
    tbl[11] = '{8'h81, 7, 2'b11, 8'h03};

    // Reset held two cycles with requests offered; none may ever emerge.
    rst = 1'b1;
    for (int l = 0; l < 3; l++) begin
      iv[l] = 1'b1; idat[l] = $urandom; iamt[l] = 1; imode[l] = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int l = 0; l < 3; l++) iv[l] = 1'b0;
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("rst_out_valid_l%0d", l), 32'(ov[l]), 32'd0);
      chk($sformatf("rst_out_data_l%0d", l), odat[l], 32'd0);
      chk($sformatf("rst_in_ready_l%0d", l), 32'(irdy[l]), 32'd1);
    end
    repeat (6) @(negedge clk);

    // Directed vectors, back-to-back on the 8-bit lane.
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) send(0, 32'(tbl[i].d), tbl[i].a, tbl[i].m, 32'(tbl[i].e));
    repeat (8) @(posedge clk);
    #1;

    // Random streams on all widths: free-flowing first, then random backpressure.
    for (int i = 0; i < 150; i++) begin
      ordy_mode = (i < 60) ? 0 : 2;
      fork
        send_rand(0);
        send_rand(1);
        send_rand(2);
      join
    end

    // Periodic backpressure 1,0,0 on an 8-request stream.
    ordy_mode = 1;
    for (int i = 0; i < 8; i++) send_rand(0);
    repeat (30) @(posedge clk);
    ordy_mode = 0;
    repeat (10) @(posedge clk);
    #1;

    // Reset while requests are in flight.
    send(0, 32'h3C, 2, 2'b11, model(8, 32'h3C, 2, 2'b11));
    send(0, 32'h96, 5, 2'b10, model(8, 32'h96, 5, 2'b10));
    iv[0] = 1'b1; idat[0] = 32'h55; iamt[0] = 1; imode[0] = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    iv[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_quiet", 32'(ov[0]), 32'd0);
    end
    @(posedge clk); #1;
    send(0, 32'h81, 3, 2'b10, 32'hF0);
    repeat (12) @(negedge clk);
    for (int l = 0; l < 3; l++) chk($sformatf("drain_l%0d", l), 32'(wp[l] - rp[l]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
